// File: rtl/result_fifo.sv
// result_fifo: 8-entry first-word-fall-through buffer for the 4-bit
// arithmetic block's results, with a valid/ready consumer handshake and a
// sticky overflow flag for results dropped while full.
// Optional build macro RESULT_FIFO_STATS_EN adds running sum / max_seen outputs.
module result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [PTR_W:0]   count,
    output logic             overflow
`ifdef RESULT_FIFO_STATS_EN
    ,
    output logic [WIDTH+7:0] sum,
    output logic [WIDTH-1:0] max_seen
`endif
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;

    // Handshake flags come from registered occupancy only, so no input
    // reaches an output combinationally.
    always_comb begin
        in_ready  = (count_q != FULL_CNT);
        out_valid = (count_q != '0);
        out_data  = mem_q[rd_ptr_q];
        count     = count_q;
        overflow  = overflow_q;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Next-state for storage, pointers, occupancy and the sticky overflow.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
        if (in_valid && !in_ready) begin
            overflow_d = 1'b1;
        end
    end

    // Control registers; reset wins over any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array holds no reset; stale entries are hidden behind count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef RESULT_FIFO_STATS_EN
    logic [WIDTH+7:0] sum_q, sum_d;
    logic [WIDTH-1:0] max_seen_q, max_seen_d;

    // Running statistics over accepted pushes only; dropped data is ignored.
    always_comb begin
        sum_d      = sum_q;
        max_seen_d = max_seen_q;
        if (push) begin
            sum_d = sum_q + (WIDTH+8)'(in_data);
            if (in_data > max_seen_q) begin
                max_seen_d = in_data;
            end
        end
        sum      = sum_q;
        max_seen = max_seen_q;
    end

    // Statistics registers, cleared with the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q      <= '0;
            max_seen_q <= '0;
        end else begin
            sum_q      <= sum_d;
            max_seen_q <= max_seen_d;
        end
    end
`endif

endmodule

// File: tb/tb_result_fifo.sv
// Directed self-checking bench for result_fifo (both build variants).
module tb_result_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [PTR_W:0]   count;
    logic             overflow;
`ifdef RESULT_FIFO_STATS_EN
    logic [WIDTH+7:0] sum;
    logic [WIDTH-1:0] max_seen;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
`ifdef RESULT_FIFO_STATS_EN
        ,
        .sum       (sum),
        .max_seen  (max_seen)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_head;
        logic [WIDTH-1:0] nxt;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_overflow", 32'(overflow), 0);

        // empty pop request is ignored
        out_ready = 1'b1;
        tick();
        check("empty_pop_count", 32'(count), 0);
        out_ready = 1'b0;

        // fill 1..8 with consumer stalled
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(i);
            tick();
            check("fill_count", 32'(count), 32'(i));
            if (i == 1) begin
                check("fill_first_valid", 32'(out_valid), 1);
                check("fill_first_head", 32'(out_data), 1);
            end
        end
        check("full_in_ready", 32'(in_ready), 0);
        check("full_no_ovf_yet", 32'(overflow), 0);
        in_data = 4'd9;
        tick();
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(count), 8);
        check("ovf_head", 32'(out_data), 1);
        in_valid = 1'b0;

        // drain 1..8
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_valid", 32'(out_valid), 1);
            check("drain_data", 32'(out_data), 32'(i));
            tick();
        end
        check("drain_empty", 32'(out_valid), 0);
        check("drain_count", 32'(count), 0);
        check("drain_ovf_sticky", 32'(overflow), 1);

        // streaming: prime one entry, then push+pop every cycle
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'd1;
        tick();
        exp_head = 4'd1;
        nxt = 4'd2;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = nxt;
            check("stream_head", 32'(out_data), 32'(exp_head));
            tick();
            check("stream_count", 32'(count), 1);
            exp_head = nxt;
            nxt = (nxt == 4'd9) ? 4'd1 : nxt + 4'd1;
        end
        in_valid = 1'b0;
        check("stream_last", 32'(out_data), 32'(exp_head));
        tick();
        check("stream_drained", 32'(count), 0);
        out_ready = 1'b0;

        // mid-operation reset with 5 stored; concurrent push/pop ignored
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(10 + i);
            tick();
        end
        check("mid_count5", 32'(count), 5);
        reset = 1'b1; in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        in_valid = 1'b1; in_data = 4'd3;
        tick();
        in_valid = 1'b0;
        check("post_rst_head", 32'(out_data), 3);
        check("post_rst_count", 32'(count), 1);

        // full with simultaneous pop: push refused, pop proceeds
        for (int i = 2; i <= 8; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(i);
            tick();
        end
        check("refill_count", 32'(count), 8);
        in_data = 4'hE; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("fullpop_count", 32'(count), 7);
        check("fullpop_in_ready", 32'(in_ready), 1);
        check("fullpop_head", 32'(out_data), 2);
        check("fullpop_ovf", 32'(overflow), 1);

`ifdef RESULT_FIFO_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("stats_rst_sum", 32'(sum), 0);
        check("stats_rst_max", 32'(max_seen), 0);
        in_valid = 1'b1; in_data = 4'd1; tick();
        in_data = 4'd9; tick();
        in_data = 4'd4; tick();
        in_valid = 1'b0;
        check("stats_sum", 32'(sum), 14);
        check("stats_max", 32'(max_seen), 9);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 4'd2; tick();
        end
        check("stats_full_count", 32'(count), 8);
        check("stats_sum_full", 32'(sum), 24);
        in_data = 4'hF; tick();
        in_valid = 1'b0;
        check("stats_ovf_sum", 32'(sum), 24);
        check("stats_ovf_max", 32'(max_seen), 9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
